// File: rtl/rom_phase_sequencer_if.sv
// ROM-side bus of the phase sequencer: address/enable out, three phase words back.
interface rom_phase_sequencer_if #(
  parameter int ADDR_BITS  = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  rom_en;
  logic [ADDR_BITS-1:0]  rom_addr;
  logic [DATA_WIDTH-1:0] rom_d1;
  logic [DATA_WIDTH-1:0] rom_d2;
  logic [DATA_WIDTH-1:0] rom_d3;

  modport master (
    output rom_en,
    output rom_addr,
    input  rom_d1,
    input  rom_d2,
    input  rom_d3
  );

  modport slave (
    input  rom_en,
    input  rom_addr,
    output rom_d1,
    output rom_d2,
    output rom_d3
  );
endinterface

// File: rtl/rom_phase_sequencer.sv
// Phase-accumulator ROM sequencer with prescaled ticks, shadowed FCW and clean park-at-zero stop.
// Optional macro SEQ_ROUND_EN: round-to-nearest ROM addressing instead of truncation.
module rom_phase_sequencer #(
  parameter int ADDR_BITS  = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_BITS   = 32,
  parameter int DIV_BITS   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [DIV_BITS-1:0]   div,
  input  logic [ACC_BITS-1:0]   fcw_in,
  input  logic                  fcw_load,
  output logic                  fcw_ack,
  rom_phase_sequencer_if.master rom,
  output logic [DATA_WIDTH-1:0] ph_a,
  output logic [DATA_WIDTH-1:0] ph_b,
  output logic [DATA_WIDTH-1:0] ph_c,
  output logic                  sample_valid,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state_reg, state_next;
  logic [ACC_BITS-1:0]   acc_reg, acc_next;
  logic [ACC_BITS-1:0]   fcw_act_reg, fcw_act_next;
  logic [ACC_BITS-1:0]   shadow_reg, shadow_next;
  logic [DIV_BITS-1:0]   div_cnt_reg, div_cnt_next;
  logic [DIV_BITS-1:0]   div_lat_reg, div_lat_next;
  logic                  cap_pend_reg, cap_pend_next;
  logic                  pend_reg, pend_next;
  logic                  fcw_ack_reg, fcw_ack_next;
  logic                  sample_valid_reg, sample_valid_next;
  logic [DATA_WIDTH-1:0] ph_a_reg, ph_a_next;
  logic [DATA_WIDTH-1:0] ph_b_reg, ph_b_next;
  logic [DATA_WIDTH-1:0] ph_c_reg, ph_c_next;

  logic                  tick;
  logic                  copy;
  logic [ACC_BITS-1:0]   fcw_eff;
  logic [ACC_BITS:0]     sum;

  // A pending word takes effect on the tick that consumes it, so the add sees the new value.
  always_comb begin
    tick    = (state_reg != IDLE) && (div_cnt_reg == div_lat_reg);
    copy    = pend_reg && (tick || (state_reg == IDLE));
    fcw_eff = copy ? shadow_reg : fcw_act_reg;
    sum     = {1'b0, acc_reg} + {1'b0, fcw_eff};
  end

  always_comb begin
    state_next        = state_reg;
    acc_next          = acc_reg;
    fcw_act_next      = fcw_act_reg;
    shadow_next       = shadow_reg;
    div_cnt_next      = div_cnt_reg;
    div_lat_next      = div_lat_reg;
    cap_pend_next     = cap_pend_reg;
    pend_next         = pend_reg;
    fcw_ack_next      = copy;
    sample_valid_next = 1'b0;
    ph_a_next         = ph_a_reg;
    ph_b_next         = ph_b_reg;
    ph_c_next         = ph_c_reg;

    if (copy) begin
      fcw_act_next = shadow_reg;
      pend_next    = 1'b0;
    end
    if (fcw_load) begin
      shadow_next = fcw_in;
      pend_next   = 1'b1;
    end

    if (cap_pend_reg) begin
      ph_a_next         = rom.rom_d1;
      ph_b_next         = rom.rom_d2;
      ph_c_next         = rom.rom_d3;
      sample_valid_next = 1'b1;
      cap_pend_next     = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next    = RUN;
          acc_next      = '0;
          div_cnt_next  = '0;
          div_lat_next  = div;
          cap_pend_next = 1'b1;
        end
      end
      RUN, DRAIN: begin
        if (tick) begin
          div_cnt_next  = '0;
          acc_next      = sum[ACC_BITS-1:0];
          cap_pend_next = 1'b1;
        end else begin
          div_cnt_next = div_cnt_reg + DIV_BITS'(1);
        end
        if ((state_reg == RUN) && stop) begin
          state_next = DRAIN;
        end
        // Park on wrap-around (carry out) or when the active word is zero and would never wrap.
        if ((state_reg == DRAIN) && tick && (sum[ACC_BITS] || (fcw_eff == '0))) begin
          acc_next   = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      acc_reg          <= '0;
      fcw_act_reg      <= '0;
      shadow_reg       <= '0;
      div_cnt_reg      <= '0;
      div_lat_reg      <= '0;
      cap_pend_reg     <= 1'b0;
      pend_reg         <= 1'b0;
      fcw_ack_reg      <= 1'b0;
      sample_valid_reg <= 1'b0;
      ph_a_reg         <= '0;
      ph_b_reg         <= '0;
      ph_c_reg         <= '0;
    end else begin
      state_reg        <= state_next;
      acc_reg          <= acc_next;
      fcw_act_reg      <= fcw_act_next;
      shadow_reg       <= shadow_next;
      div_cnt_reg      <= div_cnt_next;
      div_lat_reg      <= div_lat_next;
      cap_pend_reg     <= cap_pend_next;
      pend_reg         <= pend_next;
      fcw_ack_reg      <= fcw_ack_next;
      sample_valid_reg <= sample_valid_next;
      ph_a_reg         <= ph_a_next;
      ph_b_reg         <= ph_b_next;
      ph_c_reg         <= ph_c_next;
    end
  end

  assign busy         = (state_reg != IDLE);
  assign fcw_ack      = fcw_ack_reg;
  assign sample_valid = sample_valid_reg;
  assign ph_a         = ph_a_reg;
  assign ph_b         = ph_b_reg;
  assign ph_c         = ph_c_reg;
  assign rom.rom_en   = busy | cap_pend_reg;

`ifdef SEQ_ROUND_EN
  assign rom.rom_addr = acc_reg[ACC_BITS-1 -: ADDR_BITS]
                      + ADDR_BITS'(acc_reg[ACC_BITS-ADDR_BITS-1]);
`else
  assign rom.rom_addr = acc_reg[ACC_BITS-1 -: ADDR_BITS];
`endif

endmodule

// File: tb/tb_rom_phase_sequencer.sv
// Directed bench for rom_phase_sequencer: reset, stepping, prescale, FCW update, drain, rounding.
module tb_rom_phase_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] div = 16'd0;
  logic [31:0] fcw_in = 32'd0;
  logic        fcw_load = 1'b0;
  logic        fcw_ack;
  logic [15:0] ph_a, ph_b, ph_c;
  logic        sample_valid;
  logic        busy;
  int          checks = 0;
  int          errors = 0;

  rom_phase_sequencer_if #(.ADDR_BITS(16), .DATA_WIDTH(16)) rom_bus ();

  function automatic logic [15:0] rom_a(input logic [15:0] a);
    return a * 16'd3 + 16'd5;
  endfunction
  function automatic logic [15:0] rom_b(input logic [15:0] a);
    return a + 16'h5555;
  endfunction
  function automatic logic [15:0] rom_c(input logic [15:0] a);
    return ~a;
  endfunction

  assign rom_bus.rom_d1 = rom_a(rom_bus.rom_addr);
  assign rom_bus.rom_d2 = rom_b(rom_bus.rom_addr);
  assign rom_bus.rom_d3 = rom_c(rom_bus.rom_addr);

  rom_phase_sequencer #(
    .ADDR_BITS(16), .DATA_WIDTH(16), .ACC_BITS(32), .DIV_BITS(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .div(div),
    .fcw_in(fcw_in), .fcw_load(fcw_load), .fcw_ack(fcw_ack), .rom(rom_bus),
    .ph_a(ph_a), .ph_b(ph_b), .ph_c(ph_c),
    .sample_valid(sample_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    $display("chk %-14s obs=%0h exp=%0h", tag, obs, exp);
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_fcw(input logic [31:0] w);
    fcw_in   = w;
    fcw_load = 1'b1;
    step();
    fcw_load = 1'b0;
    check("load_no_ack", 32'(fcw_ack), 0);
    step();
    check("idle_ack", 32'(fcw_ack), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    #1 rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_busy", 32'(busy), 0);
    check("rst_rom_en", 32'(rom_bus.rom_en), 0);
    check("rst_addr", 32'(rom_bus.rom_addr), 0);
    check("rst_valid", 32'(sample_valid), 0);
    check("rst_ack", 32'(fcw_ack), 0);
    check("rst_ph_a", 32'(ph_a), 0);

    // Basic stepping: one address per clock, samples lag by one clock
    load_fcw(32'h0001_0000);
    step();
    check("ack_single", 32'(fcw_ack), 0);
    div   = 16'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("run_busy", 32'(busy), 1);
    check("run_rom_en", 32'(rom_bus.rom_en), 1);
    check("run_addr0", 32'(rom_bus.rom_addr), 0);
    check("run_valid0", 32'(sample_valid), 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("step_addr", 32'(rom_bus.rom_addr), 32'(k));
      check("step_valid", 32'(sample_valid), 1);
      check("step_ph_a", 32'(ph_a), 32'(rom_a(16'(k - 1))));
      check("step_ph_c", 32'(ph_c), 32'(rom_c(16'(k - 1))));
    end
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_in_run", 32'(rom_bus.rom_addr), 6);

    // Asynchronous reset with an FCW still pending
    fcw_in   = 32'h0002_0000;
    fcw_load = 1'b1;
    step();
    fcw_load = 1'b0;
    check("pre_rst_addr", 32'(rom_bus.rom_addr), 7);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_rom_en", 32'(rom_bus.rom_en), 0);
    check("arst_addr", 32'(rom_bus.rom_addr), 0);
    check("arst_valid", 32'(sample_valid), 0);
    check("arst_ph_a", 32'(ph_a), 0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_ack", 32'(fcw_ack), 0);
    check("post_rst_valid", 32'(sample_valid), 0);
    step();
    check("post_rst_ack2", 32'(fcw_ack), 0);
    check("post_rst_busy", 32'(busy), 0);

    // Prescale div=3, then two loads before one tick
    load_fcw(32'h0001_0000);
    div   = 16'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    check("pre_addr0", 32'(rom_bus.rom_addr), 0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("pre_addr", 32'(rom_bus.rom_addr), 32'(k / 4));
      check("pre_valid", 32'(sample_valid), (k == 1) ? 1 : 0);
    end
    fcw_in   = 32'h0003_0000;
    fcw_load = 1'b1;
    step();
    check("pre_valid5", 32'(sample_valid), 1);
    check("pre_ph_a5", 32'(ph_a), 32'(rom_a(16'd1)));
    check("dbl_ack5", 32'(fcw_ack), 0);
    fcw_in = 32'h0002_0000;
    step();
    fcw_load = 1'b0;
    check("dbl_ack6", 32'(fcw_ack), 0);
    check("pre_valid6", 32'(sample_valid), 0);
    step();
    check("dbl_ack7", 32'(fcw_ack), 0);
    check("dbl_addr7", 32'(rom_bus.rom_addr), 1);
    step();
    check("dbl_ack8", 32'(fcw_ack), 1);
    check("dbl_addr8", 32'(rom_bus.rom_addr), 3);
    step();
    check("dbl_ack9", 32'(fcw_ack), 0);
    check("dbl_ph_a9", 32'(ph_a), 32'(rom_a(16'd3)));
    step();
    step();
    step();
    check("dbl_ack12", 32'(fcw_ack), 0);
    check("dbl_addr12", 32'(rom_bus.rom_addr), 5);
    do_reset();

    // Single FCW update at div=1
    load_fcw(32'h0001_0000);
    div   = 16'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("upd_valid1", 32'(sample_valid), 1);
    check("upd_ph_a1", 32'(ph_a), 32'(rom_a(16'd0)));
    step();
    check("upd_addr2", 32'(rom_bus.rom_addr), 1);
    fcw_in   = 32'h0002_0000;
    fcw_load = 1'b1;
    step();
    fcw_load = 1'b0;
    check("upd_addr3", 32'(rom_bus.rom_addr), 1);
    check("upd_ack3", 32'(fcw_ack), 0);
    step();
    check("upd_addr4", 32'(rom_bus.rom_addr), 3);
    check("upd_ack4", 32'(fcw_ack), 1);
    step();
    check("upd_ack5", 32'(fcw_ack), 0);
    check("upd_ph_a5", 32'(ph_a), 32'(rom_a(16'd3)));
    step();
    check("upd_addr6", 32'(rom_bus.rom_addr), 5);
    do_reset();

    // Stop/drain: start+stop together starts; later stop parks at 0
    load_fcw(32'h4000_0000);
    div   = 16'd0;
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    check("drn_busy0", 32'(busy), 1);
    check("drn_addr0", 32'(rom_bus.rom_addr), 0);
    step();
    check("drn_addr1", 32'(rom_bus.rom_addr), 32'h4000);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("drn_addr2", 32'(rom_bus.rom_addr), 32'h8000);
    check("drn_busy2", 32'(busy), 1);
    step();
    check("drn_addr3", 32'(rom_bus.rom_addr), 32'hC000);
    check("drn_busy3", 32'(busy), 1);
    step();
    check("drn_addr4", 32'(rom_bus.rom_addr), 0);
    check("drn_busy4", 32'(busy), 0);
    check("drn_rom_en4", 32'(rom_bus.rom_en), 1);
    check("drn_ph_a4", 32'(ph_a), 32'(rom_a(16'hC000)));
    step();
    check("drn_valid5", 32'(sample_valid), 1);
    check("drn_ph_a5", 32'(ph_a), 32'(rom_a(16'd0)));
    check("drn_ph_b5", 32'(ph_b), 32'(rom_b(16'd0)));
    check("drn_rom_en5", 32'(rom_bus.rom_en), 0);
    step();
    check("drn_valid6", 32'(sample_valid), 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_idle_busy", 32'(busy), 0);
    check("stop_idle_vld", 32'(sample_valid), 0);

    // Address rounding versus truncation with fcw = half an address step
    load_fcw(32'h0000_8000);
    start = 1'b1;
    step();
    start = 1'b0;
    check("rnd_addr0", 32'(rom_bus.rom_addr), 0);
    for (int k = 1; k <= 4; k++) begin
      step();
`ifdef SEQ_ROUND_EN
      check("rnd_addr", 32'(rom_bus.rom_addr), 32'((k + 1) / 2));
`else
      check("trunc_addr", 32'(rom_bus.rom_addr), 32'(k / 2));
`endif
    end
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
